// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch, fetch-side halt FSM
// and fetch/stall performance counters.
module fetch_stage #(
  parameter int unsigned CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      imemaddr,
  input  logic [31:0]      npc,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             stall,
  input  logic             flush,
  output logic             imemREN,
  output logic             pc_en,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_npc,
  output logic             ifid_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;

  typedef enum logic {
    RUN      = 1'b0,
    HALTWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] npc;
    logic              valid;
  } ifid_t;

  state_t            state_q, state_d;
  ifid_t             ifid_q, ifid_d;
  logic [CNT_W-1:0]  fetch_cnt_q, stall_cnt_q;
  logic              run;
  logic              halt_now;
  logic              capture;
  logic              stall_cycle;
  logic [OP_W-1:0]   opcode;

  assign opcode      = imemload[WORD_W-1 -: OP_W];
  assign run         = (state_q == RUN);
  assign halt_now    = ihit & (opcode == HALT_OP);
  assign capture     = run & ihit & ~stall & ~flush;
  assign stall_cycle = run & ~flush & (~ihit | stall);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and combinational control; the PC holds on a HALT address
  always_comb begin
    state_d = state_q;
    imemREN = 1'b0;
    pc_en   = flush;
    unique case (state_q)
      RUN: begin
        imemREN = 1'b1;
        if (ihit && !stall && !halt_now) begin
          pc_en = 1'b1;
        end
        if (capture && halt_now) begin
          state_d = HALTWAIT;
        end
      end
      HALTWAIT: begin
        // A flush means the HALT was fetched down the wrong path
        if (flush) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // IF/ID next value: flush beats stall beats capture, otherwise a bubble
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d.instr = '0;
      ifid_d.valid = 1'b0;
    end else if (stall) begin
      ifid_d = ifid_q;
    end else if (capture) begin
      ifid_d.instr = imemload;
      ifid_d.pc    = imemaddr;
      ifid_d.npc   = npc;
      ifid_d.valid = 1'b1;
    end else begin
      ifid_d.instr = '0;
      ifid_d.valid = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifid_q <= '0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  // Performance counters wrap freely
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (stall_cycle) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_npc   = ifid_q.npc;
  assign ifid_valid = ifid_q.valid;
  assign halted     = (state_q == HALTWAIT);
  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: capture, misses, stalls, flushes, halt,
// counter wrap (CNT_W=4) and asynchronous reset.
module tb_fetch_stage;

  localparam int unsigned CNT_W = 4;

  logic             CLK;
  logic             nRST;
  logic [31:0]      imemaddr;
  logic [31:0]      npc;
  logic             ihit;
  logic [31:0]      imemload;
  logic             stall;
  logic             flush;
  logic             imemREN;
  logic             pc_en;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_npc;
  logic             ifid_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.CNT_W(CNT_W), .HALT_OP(6'h3F)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemaddr   (imemaddr),
    .npc        (npc),
    .ihit       (ihit),
    .imemload   (imemload),
    .stall      (stall),
    .flush      (flush),
    .imemREN    (imemREN),
    .pc_en      (pc_en),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [31:0] ld, input logic [31:0] a,
                       input logic s, input logic f);
    ihit     = h;
    imemload = ld;
    imemaddr = a;
    npc      = a + 32'd4;
    stall    = s;
    flush    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] np, input logic v);
    chk({tag, ".instr"}, ifid_instr, ins);
    chk({tag, ".pc"},    ifid_pc,    pc);
    chk({tag, ".npc"},   ifid_npc,   np);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #11;
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.imemREN", 32'(imemREN), 32'd1);
    chk("reset.halted", 32'(halted), 32'd0);
    chk("reset.fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    nRST = 1'b1;

    // First capture
    drive(1'b1, 32'h2001_0005, 32'h0, 1'b0, 1'b0);
    chk("hit0.pc_en", 32'(pc_en), 32'd1);
    tick();
    chk_ifid("cap0", 32'h2001_0005, 32'h0, 32'h4, 1'b1);
    chk("cap0.fetch_cnt", 32'(fetch_cnt), 32'd1);

    // Three misses
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 32'h4, 1'b0, 1'b0);
      chk("miss.pc_en", 32'(pc_en), 32'd0);
      tick();
      chk("miss.valid", 32'(ifid_valid), 32'd0);
      chk("miss.instr", ifid_instr, 32'h0);
    end
    chk("miss.stall_cnt", 32'(stall_cnt), 32'd3);

    drive(1'b1, 32'h8C22_0000, 32'h4, 1'b0, 1'b0);
    chk("hit1.pc_en", 32'(pc_en), 32'd1);
    tick();
    chk_ifid("cap1", 32'h8C22_0000, 32'h4, 32'h8, 1'b1);
    chk("cap1.fetch_cnt", 32'(fetch_cnt), 32'd2);

    // Hazard stall holds IF/ID
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_0020, 32'h8, 1'b1, 1'b0);
      chk("stall.pc_en", 32'(pc_en), 32'd0);
      tick();
      chk_ifid("stall", 32'h8C22_0000, 32'h4, 32'h8, 1'b1);
    end
    chk("stall.stall_cnt", 32'(stall_cnt), 32'd5);
    chk("stall.fetch_cnt", 32'(fetch_cnt), 32'd2);

    // Flush beats stall
    drive(1'b1, 32'h0000_0020, 32'h8, 1'b1, 1'b1);
    chk("flst.pc_en", 32'(pc_en), 32'd1);
    tick();
    chk_ifid("flst", 32'h0, 32'h4, 32'h8, 1'b0);
    chk("flst.stall_cnt", 32'(stall_cnt), 32'd5);

    // Flush with HALT hit: no capture, stay running
    drive(1'b1, 32'hFC00_0000, 32'h20, 1'b0, 1'b1);
    chk("flhalt.pc_en", 32'(pc_en), 32'd1);
    tick();
    chk("flhalt.halted", 32'(halted), 32'd0);
    chk("flhalt.valid", 32'(ifid_valid), 32'd0);
    chk("flhalt.fetch_cnt", 32'(fetch_cnt), 32'd2);

    // HALT capture
    drive(1'b1, 32'hFC00_0000, 32'h40, 1'b0, 1'b0);
    chk("halt.pc_en", 32'(pc_en), 32'd0);
    chk("halt.imemREN", 32'(imemREN), 32'd1);
    tick();
    chk_ifid("halt", 32'hFC00_0000, 32'h40, 32'h44, 1'b1);
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.imemREN_off", 32'(imemREN), 32'd0);
    chk("halt.fetch_cnt", 32'(fetch_cnt), 32'd3);

    // Stalled HALT holds, then bubbles; no stall counting while halted
    drive(1'b1, 32'hFC00_0000, 32'h40, 1'b1, 1'b0);
    chk("hw_stall.pc_en", 32'(pc_en), 32'd0);
    tick();
    chk_ifid("hw_stall", 32'hFC00_0000, 32'h40, 32'h44, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h2001_0005, 32'h40, 1'b0, 1'b0);
      chk("hw.pc_en", 32'(pc_en), 32'd0);
      tick();
      chk("hw.valid", 32'(ifid_valid), 32'd0);
      chk("hw.instr", ifid_instr, 32'h0);
      chk("hw.halted", 32'(halted), 32'd1);
    end
    chk("hw.stall_cnt", 32'(stall_cnt), 32'd5);
    chk("hw.fetch_cnt", 32'(fetch_cnt), 32'd3);

    // Flush releases halt
    drive(1'b0, 32'h0, 32'h80, 1'b0, 1'b1);
    chk("unhalt.pc_en", 32'(pc_en), 32'd1);
    tick();
    chk("unhalt.halted", 32'(halted), 32'd0);
    chk("unhalt.imemREN", 32'(imemREN), 32'd1);
    chk("unhalt.stall_cnt", 32'(stall_cnt), 32'd5);

    drive(1'b1, 32'h1234_5678, 32'h80, 1'b0, 1'b0);
    tick();
    chk_ifid("cap2", 32'h1234_5678, 32'h80, 32'h84, 1'b1);

    // Asynchronous reset with ihit high
    drive(1'b1, 32'h1111_2222, 32'h84, 1'b0, 1'b0);
    nRST = 1'b0;
    #1;
    chk_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("arst.fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("arst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("arst.halted", 32'(halted), 32'd0);
    chk("arst.imemREN", 32'(imemREN), 32'd1);
    tick();
    chk("arst_hold.valid", 32'(ifid_valid), 32'd0);
    chk("arst_hold.fetch_cnt", 32'(fetch_cnt), 32'd0);
    nRST = 1'b1;

    // 17 captures wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i), 32'(i) * 32'd4, 1'b0, 1'b0);
      tick();
    end
    chk_ifid("wrap", 32'h0000_1010, 32'h40, 32'h44, 1'b1);
    chk("wrap.fetch_cnt", 32'(fetch_cnt), 32'd1);
    chk("wrap.stall_cnt", 32'(stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch of the pipelined MIPS core.
- Sits directly downstream of the program counter. Consumes the PC block's imemaddr/nPC and the icache's ihit/imemload.
- Produces the IF/ID register consumed by decode, and generates the PC advance enable.
- Owns the fetch-side halt state machine and two fetch performance counters.

Parameters:
- CNT_W, 32, width of the fetch_cnt and stall_cnt performance counters (wrap modulo 2^CNT_W).
- HALT_OP, 6'h3F, opcode in imemload[31:26] that marks a HALT instruction.

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemaddr  input  32  address currently presented to icache (from PC block).
- npc  input  32  imemaddr+4 from PC block.
- ihit  input  1  icache hit; imemload valid this cycle.
- imemload  input  32  instruction word from icache.
- stall  input  1  hazard unit: hold IF/ID and PC.
- flush  input  1  taken branch/jump resolved downstream: squash IF/ID and redirect PC.
- imemREN  output  1  icache read enable.
- pc_en  output  1  PC register load enable.
- ifid_instr  output  32  latched instruction.
- ifid_pc  output  32  address of latched instruction.
- ifid_npc  output  32  latched PC+4.
- ifid_valid  output  1  latched instruction is real (not bubble).
- halted  output  1  state != RUN.
- fetch_cnt  output  CNT_W  instructions captured.
- stall_cnt  output  CNT_W  fetch stall cycles.

Behaviour:
- Interface: one clock (CLK); reset nRST is asynchronous and active-low.
- Reset (nRST=0, asynchronous):
  - ifid_instr, ifid_pc, ifid_npc = 0; ifid_valid = 0.
  - state = RUN; fetch_cnt = stall_cnt = 0.
  - Combinational outputs evaluate from reset state: imemREN=1, halted=0.
- FSM states:
  - RUN: fetching.
  - HALTWAIT: HALT captured; fetch stopped.
- imemREN = (state==RUN).
- pc_en is combinational: flush | (state==RUN & ihit & ~stall & ~halt_now).
  - halt_now = ihit & imemload[31:26]==HALT_OP.
  - The PC stays on the HALT address.
- capture = state==RUN & ihit & ~stall & ~flush.
- IF/ID update priority, per cycle:
  1. flush: instr=0, valid=0; pc and npc hold. Wins over stall and ihit.
  2. stall: all IF/ID fields hold.
  3. capture: instr<=imemload, pc<=imemaddr, npc<=npc, valid<=1. One-cycle latency, ihit to ifid_valid.
  4. Otherwise (miss, or HALTWAIT): bubble, instr=0, valid=0.
- Transitions:
  - RUN -> HALTWAIT on capture & halt_now.
  - HALTWAIT -> RUN on flush (HALT was on the wrong path).
  - Flush in the same cycle as a HALT hit: no capture, stays RUN.
  - All other cases hold state.
- HALTWAIT: ifid holds the HALT while stall is asserted, then bubbles. pc_en=0 unless flush.
- halted = (state==HALTWAIT).
- fetch_cnt increments on capture.
- stall_cnt increments each cycle with state==RUN & ~flush & (~ihit | stall).
- Both counters wrap to 0 and never saturate. Neither counts during reset.
- Reset asserted mid-operation clears everything at once, even with ihit high.

Test Plan:
- Reset, then ihit=1 with imemload=0x20010005 at imemaddr 0x0 (npc 0x4) -> next edge: ifid_instr=0x20010005, ifid_pc=0x0, ifid_npc=0x4, valid=1; pc_en=1 during the hit cycle; fetch_cnt=1.
- ihit=0 for 3 cycles, then hit -> 3 bubble cycles (valid=0, instr=0), pc_en=0, stall_cnt=3; capture on the 4th cycle.
- Capture 0x8C220000, then stall=1 for 2 cycles with ihit=1 -> IF/ID holds 0x8C220000, pc_en=0, stall_cnt+=2, fetch_cnt unchanged.
- stall=1 and flush=1 in the same cycle -> IF/ID becomes bubble, pc_en=1, stall_cnt unchanged.
- Fetch 0xFC000000 at 0x40 -> captured, halted=1 next cycle, imemREN=0, pc_en=0; following cycles are bubbles. Then flush -> halted=0, imemREN=1, pc_en=1.
- CNT_W=4, 17 consecutive captures -> fetch_cnt reads 1 (wrapped). Assert nRST mid-stream -> all outputs zero immediately, asynchronously.
